// File: rtl/alu_pkg.sv
// Shared ALU control codes and issue-unit FSM states.
// Imported by the issue unit and its testbench.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_MOD     = 4'b0100;
    localparam logic [3:0] ALU_MUL     = 4'b0101;
    localparam logic [3:0] ALU_SHR     = 4'b0110;
    localparam logic [3:0] ALU_LAST_OP = ALU_SHR;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } issue_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= ALU_LAST_OP;
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request, ALU-side and response signals of the ALU issue unit.
// slave = issue unit, master = requester / ALU / consumer side.
interface alu_issue_unit_if #(
    parameter int N = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [15:0]  op_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_result, rsp_flags,
        output rsp_err, op_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_result, rsp_flags,
        input  rsp_err, op_count
    );

endinterface

// File: rtl/alu_issue_unit.sv
// Issues one operation at a time to an external combinational ALU,
// waits SETTLE cycles, captures its outputs and holds the response.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int N      = 8,
    parameter int SETTLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_unit_if.slave bus
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    issue_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_ctrl_q, alu_ctrl_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_err_q, rsp_err_d;
    logic [15:0]  op_count_q, op_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= ALU_ADD;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (op_legal(bus.req_op)) begin
                        alu_a_d    = bus.req_a;
                        alu_b_d    = bus.req_b;
                        alu_ctrl_d = bus.req_op;
                        cnt_d      = SETTLE_M1;
                        state_d    = ST_SETTLE;
                    end else begin
                        // ALU operands keep the last legal op
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = bus.alu_result;
                    rsp_flags_d  = bus.alu_flags;
                    rsp_err_d    = 1'b0;
                    op_count_d   = op_count_q + 16'd1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = rst_n && (state_q == ST_IDLE);
        bus.rsp_valid  = (state_q == ST_RESP);
        bus.alu_a      = alu_a_q;
        bus.alu_b      = alu_b_q;
        bus.alu_ctrl   = alu_ctrl_q;
        bus.rsp_result = rsp_result_q;
        bus.rsp_flags  = rsp_flags_q;
        bus.rsp_err    = rsp_err_q;
        bus.op_count   = op_count_q;
    end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits.
REQ-002 SHALL have parameter SETTLE, default 1, ALU settle cycles before capture (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  operation request valid.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_op  input  4  ALU ctrl code requested.
REQ-008 SHALL have ports req_a, req_b  input  N  operands.
REQ-009 SHALL have ports alu_a, alu_b  output  N  registered operands driven to ALU.
REQ-010 SHALL have port alu_ctrl  output  4  registered ctrl driven to ALU.
REQ-011 SHALL have port alu_result  input  N  combinational ALU result.
REQ-012 SHALL have port alu_flags  input  4  combinational ALU flags.
REQ-013 SHALL have port rsp_valid  output  1  response valid.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have ports rsp_result  output  N, rsp_flags  output  4  captured ALU outputs.
REQ-016 SHALL have port rsp_err  output  1  request had illegal op code.
REQ-017 SHALL have port op_count  output  16  count of completed legal operations.

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE: on req_valid&&req_ready at edge k with req_op <= 4'b0110, SHALL register req_a/req_b/req_op onto alu_a/alu_b/alu_ctrl and enter SETTLE with settle counter = SETTLE-1.
REQ-020 IDLE: on accepted req_op > 4'b0110, SHALL leave alu_* unchanged, enter RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
REQ-021 SETTLE: counter decrements each cycle; at counter 0, SHALL capture alu_result/alu_flags into rsp_result/rsp_flags, rsp_err=0, enter RESP; legal-op rsp_valid rises after edge k+SETTLE.
REQ-022 RESP: rsp_valid=1; rsp_result/rsp_flags/rsp_err SHALL stay stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-023 No request SHALL be accepted in the cycle of the response handshake; minimum issue interval is SETTLE+2 cycles.
REQ-024 alu_a/alu_b/alu_ctrl SHALL hold last legal values in all states (no toggling between operations).
REQ-025 op_count SHALL increment by 1 on each legal capture, wrapping 16'hFFFF -> 0; illegal ops do not count.
REQ-026 Operand/result arithmetic is performed by the external ALU only; this unit SHALL NOT modify captured values.

Reset
REQ-027 While rst_n=0: state IDLE, alu_a=alu_b=0, alu_ctrl=4'b0000, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, op_count=0, settle counter 0.
REQ-028 req_valid SHALL be ignored while rst_n=0; req_ready is 1 from the first edge after deassertion.
REQ-029 Reset asserted in SETTLE or RESP SHALL discard the in-flight operation; no rsp_valid for it after release.

Structure
REQ-030 Shared package alu_pkg SHALL hold ctrl codes ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_OR=0011, ALU_MOD=0100, ALU_MUL=0101, ALU_SHR=0110, ALU_LAST_OP=ALU_SHR, and the FSM state enum.
REQ-031 No sub-module; the ALU is instantiated beside this unit, the bench connects both.

Verification
REQ-032 SETTLE=1, ADD a=5 b=3 accepted at edge k -> rsp_valid after edge k+1, rsp_result=8, rsp_flags=0000, rsp_err=0, op_count=1.
REQ-033 MUL a=5 b=3, rsp_ready low 3 cycles -> rsp_result=15 held stable, req_ready=0 throughout, IDLE after handshake.
REQ-034 req_op=4'b1001 -> rsp_err=1, rsp_result=0, alu_ctrl unchanged, op_count unchanged.
REQ-035 SETTLE=4, SUB 5-3, rst_n pulsed low in SETTLE -> no rsp_valid, all outputs reset values, next ADD 5+3 returns 8.
REQ-036 Back-to-back AND 5&3 then OR 5|3 then MOD 5%3 then SHR 5>>1 -> results 1, 7, 2, 2 in order, issue interval exactly SETTLE+2.
REQ-037 op_count preloaded via 65535 legal ops -> wraps to 0 on the next legal capture.
